// File: rtl/slt_compare_unit_if.sv
// Request/response bundle for slt_compare_unit: operands and mode in, result/eq out.
// Each direction uses its own valid/ready pair; the unit is the slave side.
interface slt_compare_unit_if #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [IMM_WIDTH-1:0] imm;
  logic                 use_imm;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic                 result;
  logic                 eq;

  modport master (
    output in_valid, a, b, imm, use_imm, is_signed, out_ready,
    input  in_ready, out_valid, result, eq
  );

  modport slave (
    input  in_valid, a, b, imm, use_imm, is_signed, out_ready,
    output in_ready, out_valid, result, eq
  );
endinterface

// File: rtl/slt_compare_unit.sv
// Multi-cycle MSB-first set-less-than (SLT/SLTU/SLTI/SLTIU), CHUNK bits per cycle; NCHUNK-cycle latency,
// or first-differing-chunk latency with SLT_EARLY_EXIT_EN; one request at a time, result held until out_ready.
module slt_compare_unit #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter int IMM_WIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  slt_compare_unit_if.slave io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             diff_q, diff_d;
  logic             result_q, result_d;
  logic             eq_q, eq_d;

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] flip;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             step_diff;
  logic             step_lt;
  logic             finish;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    imm_ext   = WIDTH'($signed(io.imm));
    rhs       = io.use_imm ? imm_ext : io.b;
    flip      = io.is_signed ? MSB_MASK : '0;
    a_chunk   = a_q[WIDTH-1 -: CHUNK];
    b_chunk   = b_q[WIDTH-1 -: CHUNK];
    step_diff = diff_q | (a_chunk != b_chunk);
    step_lt   = diff_q ? lt_q : (a_chunk < b_chunk);
`ifdef SLT_EARLY_EXIT_EN
    finish    = (cnt_q == '0) || step_diff;
`else
    finish    = (cnt_q == '0);
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    lt_d     = lt_q;
    diff_d   = diff_q;
    result_d = result_q;
    eq_d     = eq_q;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d      = io.a ^ flip;
          b_d      = rhs ^ flip;
          cnt_d    = CNT_W'(NCHUNK - 1);
          lt_d     = 1'b0;
          diff_d   = 1'b0;
          result_d = 1'b0;
          eq_d     = 1'b0;
          state_d  = CMP;
        end
      end
      CMP: begin
        a_d    = a_q << CHUNK;
        b_d    = b_q << CHUNK;
        cnt_d  = cnt_q - CNT_W'(1);
        lt_d   = step_lt;
        diff_d = step_diff;
        if (finish) begin
          result_d = step_lt;
          eq_d     = ~step_diff;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      lt_q     <= 1'b0;
      diff_q   <= 1'b0;
      result_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      lt_q     <= lt_d;
      diff_q   <= diff_d;
      result_q <= result_d;
      eq_q     <= eq_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = result_q;
  assign io.eq        = eq_q;
endmodule

// File: tb/tb_slt_compare_unit.sv
// Randomized and directed bench for slt_compare_unit against an arithmetic reference model.
module tb_slt_compare_unit;
  localparam int WIDTH     = 16;
  localparam int CHUNK     = 4;
  localparam int IMM_WIDTH = 6;
  localparam int NCHUNK    = WIDTH / CHUNK;
  localparam int BUDGET    = 20;
`ifdef SLT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  slt_compare_unit_if #(.WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH)) bus ();

  slt_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IMM_WIDTH(IMM_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model_rhs(input logic [WIDTH-1:0] b,
                                                 input logic [IMM_WIDTH-1:0] imm,
                                                 input logic use_imm);
    logic signed [IMM_WIDTH-1:0] si;
    logic signed [WIDTH-1:0]     ext;
    si  = imm;
    ext = si;
    return use_imm ? ext : b;
  endfunction

  function automatic logic model_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] r,
                                    input logic is_signed);
    logic signed [WIDTH-1:0] sa, sr;
    sa = a;
    sr = r;
    if (is_signed) return sa < sr;
    return a < r;
  endfunction

  // Index (1-based, from the MSB) of the first differing chunk, or NCHUNK when equal.
  function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] r);
    int k_first;
    k_first = NCHUNK;
    for (int k = NCHUNK; k >= 1; k--)
      if ((a >> (WIDTH - k * CHUNK)) != (r >> (WIDTH - k * CHUNK))) k_first = k;
    return EARLY ? k_first : NCHUNK;
  endfunction

  task automatic issue_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [IMM_WIDTH-1:0] imm, input logic use_imm,
                          input logic is_signed, output logic res, output logic eqo,
                          output int lat);
    bus.a         = a;
    bus.b         = b;
    bus.imm       = imm;
    bus.use_imm   = use_imm;
    bus.is_signed = is_signed;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.a         = 16'($urandom);
    bus.b         = 16'($urandom);
    bus.imm       = 6'($urandom);
    bus.use_imm   = 1'($urandom);
    bus.is_signed = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat <= BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    eqo = bus.eq;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.eq} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_outputs: in_ready/out_valid/result/eq got %b expected 1000",
               {bus.in_ready, bus.out_valid, bus.result, bus.eq});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_idle: in_ready/out_valid got %b expected 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [IMM_WIDTH-1:0] imm;
    logic                 use_imm;
    logic                 is_signed;
    logic                 res;
    logic                 eq;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[6];
    logic res, eqo;
    int   lat, exp_lat;
    tbl[0] = '{16'h0003, 16'h0005, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 6'h3F, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{16'h1000, 16'h2000, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      exp_lat = model_latency(tbl[i].a, model_rhs(tbl[i].b, tbl[i].imm, tbl[i].use_imm));
      issue_op(tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].use_imm, tbl[i].is_signed, res, eqo, lat);
      vectors++;
      if (res !== tbl[i].res || eqo !== tbl[i].eq) begin
        miscompares++;
        $display("FAIL directed_%0d: result/eq got %b%b expected %b%b", i, res, eqo, tbl[i].res, tbl[i].eq);
      end
      vectors++;
      if (lat !== exp_lat) begin
        miscompares++;
        $display("FAIL directed_latency_%0d: got %0d cycles expected %0d", i, lat, exp_lat);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic res, eqo;
    int   lat;
    bit   saw_ov;
    issue_op(16'h1234, 16'h1234, 6'h00, 1'b0, 1'b0, res, eqo, lat);
    vectors++;
    if (res !== 1'b0 || eqo !== 1'b1 || lat !== NCHUNK) begin
      miscompares++;
      $display("FAIL equal_op: result=%b eq=%b latency=%0d expected 0 1 %0d", res, eqo, lat, NCHUNK);
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i == 1);
      bus.a        = 16'h0001;
      bus.b        = 16'h0002;
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.eq} !== 4'b1001) begin
        miscompares++;
        $display("FAIL hold_%0d: out_valid/in_ready/result/eq got %b expected 1001", i,
                 {bus.out_valid, bus.in_ready, bus.result, bus.eq});
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    finish_op();
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL release_idle: out_valid/in_ready got %b expected 01", {bus.out_valid, bus.in_ready});
    end
    saw_ov = 1'b0;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) saw_ov = 1'b1;
    end
    vectors++;
    if (saw_ov) begin
      miscompares++;
      $display("FAIL ignored_pulse: unit left IDLE after in_valid during DONE, expected it to stay idle");
    end
  endtask

  task automatic test_reset_mid();
    logic res, eqo;
    int   lat;
    bit   saw_ov;
    bus.a = 16'h5555; bus.b = 16'h5555; bus.use_imm = 1'b0; bus.is_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.eq} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_cmp: out_valid/in_ready/result/eq got %b expected 0100",
               {bus.out_valid, bus.in_ready, bus.result, bus.eq});
    end
    saw_ov = 1'b0;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      if (bus.out_valid) saw_ov = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (saw_ov) begin
      miscompares++;
      $display("FAIL abandoned_op: out_valid got 1 after reset expected 0");
    end
    issue_op(16'h0001, 16'h0002, 6'h00, 1'b0, 1'b0, res, eqo, lat);
    vectors++;
    if (res !== 1'b1 || eqo !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_op: result/eq got %b%b expected 10", res, eqo);
    end
    finish_op();
    issue_op(16'h0003, 16'h0007, 6'h00, 1'b0, 1'b0, res, eqo, lat);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.eq} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_done: out_valid/in_ready/result/eq got %b expected 0100",
               {bus.out_valid, bus.in_ready, bus.result, bus.eq});
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    bit prev_ov;
    bus.a = 16'h5A5A; bus.b = 16'h5A5A; bus.use_imm = 1'b0; bus.is_signed = 1'($urandom);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prev_ov = 1'b0;
    for (int c = 0; c < 4 * (NCHUNK + 2); c++) begin
      if (bus.in_ready) acc.push_back(c);
      if (bus.out_valid) begin
        vectors++;
        if (bus.result !== 1'b0 || bus.eq !== 1'b1 || prev_ov) begin
          miscompares++;
          $display("FAIL b2b_result: result=%b eq=%b prev_out_valid=%b expected 0 1 0", bus.result, bus.eq, prev_ov);
        end
      end
      prev_ov = bus.out_valid;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (NCHUNK + 2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (acc.size() !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: accepts got %0d expected 4", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      vectors++;
      if (acc[i] - acc[i-1] !== NCHUNK + 2) begin
        miscompares++;
        $display("FAIL b2b_period: gap got %0d expected %0d", acc[i] - acc[i-1], NCHUNK + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0]     a, b, r;
    logic [IMM_WIDTH-1:0] imm;
    logic                 u, s, res, eqo, exp_lt, exp_eq;
    int                   lat, exp_lat, hold;
    for (int n = 0; n < 300; n++) begin
      a   = 16'($urandom);
      imm = 6'($urandom);
      u   = 1'($urandom);
      s   = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (16'(1) << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      if (u && $urandom_range(0, 3) == 0) a = model_rhs(b, imm, 1'b1);
      r       = model_rhs(b, imm, u);
      exp_lt  = model_lt(a, r, s);
      exp_eq  = (a == r);
      exp_lat = model_latency(a, r);
      issue_op(a, b, imm, u, s, res, eqo, lat);
      vectors++;
      if (res !== exp_lt || eqo !== exp_eq || lat !== exp_lat) begin
        miscompares++;
        $display("FAIL random_%0d: a=%h rhs=%h signed=%b got result=%b eq=%b lat=%0d expected %b %b %0d",
                 n, a, r, s, res, eqo, lat, exp_lt, exp_eq, exp_lat);
      end
      hold = $urandom_range(0, 2);
      repeat (hold) @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp_lt || bus.eq !== exp_eq) begin
        miscompares++;
        $display("FAIL random_hold_%0d: out_valid=%b result=%b eq=%b expected 1 %b %b",
                 n, bus.out_valid, bus.result, bus.eq, exp_lt, exp_eq);
      end
      finish_op();
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.imm       = '0;
    bus.use_imm   = 1'b0;
    bus.is_signed = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
